// File: rtl/free_list_pkg.sv
// Shared rename constants and the free-list state encoding.
package free_list_pkg;

  localparam int FL_PHYS_REGS = 64;
  localparam int FL_ARCH_REGS = 32;
  localparam int FL_TAG_WIDTH = 6;

  typedef enum logic {
    FL_IDLE    = 1'b0,
    FL_REBUILD = 1'b1
  } fl_state_e;

endpackage

// File: rtl/free_list_fl_tag_fifo.sv
// Circular FIFO of physical register tags. On reset, entries
// 0..PRELOAD-1 hold tags PRELOAD..2*PRELOAD-1.
// Clear has priority over push and pop in the same cycle.
module fl_tag_fifo
  import free_list_pkg::*;
#(
  parameter int DEPTH   = FL_PHYS_REGS,
  parameter int TW      = FL_TAG_WIDTH,
  parameter int PRELOAD = FL_ARCH_REGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [TW-1:0] push_id_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [TW-1:0] head_o,
  output logic [TW:0]   count_o
);

  logic [TW-1:0] mem_q [DEPTH];
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [TW:0]   count_q, count_d;

  function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
    return (p == TW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointer and occupancy values.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_i)  head_d = ptr_inc(head_q);
      if (push_i) tail_d = ptr_inc(tail_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with the reset preload occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= TW'(PRELOAD);
      count_q <= (TW+1)'(PRELOAD);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Tag storage: preloaded on reset, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= (i < PRELOAD) ? TW'(PRELOAD + i) : '0;
    end else if (push_i && !clear_i) begin
      mem_q[tail_q] <= push_id_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/free_list.sv
// Physical register free list with retirement-RAT rebuild on recovery.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   FL_IDLE    | normal operation: grant allocs, accept frees
//   FL_REBUILD | scanning IDs 0..PHYS_REGS-1, pushing those not in RetRAT
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REGS = FL_PHYS_REGS,
  parameter int ARCH_REGS = FL_ARCH_REGS,
  parameter int TAG_WIDTH = FL_TAG_WIDTH
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           FREEZE,
  input  logic                           tFL_allocReq_IN,
  output logic                           fFL_allocValid_OUT,
  output logic [TAG_WIDTH-1:0]           fFL_allocId_OUT,
  input  logic                           tFL_freeReq_IN,
  input  logic [TAG_WIDTH-1:0]           tFL_freeId_IN,
  input  logic                           tFL_copyRetRat_IN,
  input  logic [TAG_WIDTH*ARCH_REGS-1:0] tFL_retRat_IN,
  output logic                           fFL_busy_OUT,
  output logic [TAG_WIDTH:0]             fFL_count_OUT,
  output logic                           fFL_overflow_OUT
);

  fl_state_e              state_q, state_d;
  logic [PHYS_REGS-1:0]   inuse_q, inuse_d;
  logic [PHYS_REGS-1:0]   rat_map;
  logic [TAG_WIDTH-1:0]   scan_q, scan_d;
  logic                   ovf_q, ovf_d;
  logic                   push, pop, clear, alloc_valid, full;
  logic [TAG_WIDTH-1:0]   push_id, head;
  logic [TAG_WIDTH:0]     count;

  fl_tag_fifo #(
    .DEPTH   (PHYS_REGS),
    .TW      (TAG_WIDTH),
    .PRELOAD (ARCH_REGS)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push_i    (push),
    .push_id_i (push_id),
    .pop_i     (pop),
    .clear_i   (clear),
    .head_o    (head),
    .count_o   (count)
  );

  assign full = (count == (TAG_WIDTH+1)'(PHYS_REGS));

  // Decode the RetRAT into an in-use bitmap; arch reg 0 sits in the MSB field.
  // Duplicate mappings simply set the same bit again.
  always_comb begin
    rat_map = '0;
    for (int a = 0; a < ARCH_REGS; a++)
      rat_map[tFL_retRat_IN[(ARCH_REGS-1-a)*TAG_WIDTH +: TAG_WIDTH]] = 1'b1;
  end

  // Next-state, FIFO control and alloc grant; FREEZE leaves everything idle.
  always_comb begin
    state_d     = state_q;
    inuse_d     = inuse_q;
    scan_d      = scan_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;
    alloc_valid = 1'b0;
    push_id     = tFL_freeId_IN;
    if (!FREEZE) begin
      case (state_q)
        FL_IDLE: begin
          alloc_valid = (count != '0);
          pop         = alloc_valid && tFL_allocReq_IN;
          if (tFL_copyRetRat_IN) begin
            // Frees in the copy cycle are dropped; the scan recovers them.
            state_d = FL_REBUILD;
            inuse_d = rat_map;
            scan_d  = '0;
            clear   = 1'b1;
          end else if (tFL_freeReq_IN) begin
            if (full) ovf_d = 1'b1;
            else      push  = 1'b1;
          end
        end
        FL_REBUILD: begin
          push    = !inuse_q[scan_q];
          push_id = scan_q;
          if (scan_q == TAG_WIDTH'(PHYS_REGS - 1)) begin
            state_d = FL_IDLE;
            scan_d  = '0;
          end else begin
            scan_d = scan_q + 1'b1;
          end
        end
        default: state_d = FL_IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= FL_IDLE;
      inuse_q <= '0;
      scan_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inuse_q <= inuse_d;
      scan_q  <= scan_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fFL_allocValid_OUT = alloc_valid;
  assign fFL_allocId_OUT    = head;
  assign fFL_busy_OUT       = (state_q == FL_REBUILD);
  assign fFL_count_OUT      = count;
  assign fFL_overflow_OUT   = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Free-list bench: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_free_list;

  localparam int P  = 64;
  localparam int A  = 32;
  localparam int TW = 6;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FREEZE, alloc_req, free_req, copy;
  logic [TW-1:0] free_id;
  logic [TW*A-1:0] rat;
  logic          alloc_valid, busy, ovf;
  logic [TW-1:0] alloc_id;
  logic [TW:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  int rat_ids [A];

  free_list dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .FREEZE             (FREEZE),
    .tFL_allocReq_IN    (alloc_req),
    .fFL_allocValid_OUT (alloc_valid),
    .fFL_allocId_OUT    (alloc_id),
    .tFL_freeReq_IN     (free_req),
    .tFL_freeId_IN      (free_id),
    .tFL_copyRetRat_IN  (copy),
    .tFL_retRat_IN      (rat),
    .fFL_busy_OUT       (busy),
    .fFL_count_OUT      (count),
    .fFL_overflow_OUT   (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_q[$];
  bit  m_rebuild;
  int  m_scan;
  bit  m_ovf;
  int  m_rat [A];
  bit  m_live = 0;

  function automatic void m_reset();
    m_q.delete();
    for (int i = 0; i < A; i++) m_q.push_back(A + i);
    m_rebuild = 0;
    m_scan    = 0;
    m_ovf     = 0;
  endfunction

  function automatic bit m_in_rat(int id);
    for (int a = 0; a < A; a++) if (m_rat[a] == id) return 1;
    return 0;
  endfunction

  function automatic void m_step();
    int sz;
    if (!m_rebuild) begin
      if (copy) begin
        m_q.delete();
        m_rat     = rat_ids;
        m_rebuild = 1;
        m_scan    = 0;
      end else begin
        sz = m_q.size();
        if (alloc_req && sz > 0) void'(m_q.pop_front());
        if (free_req) begin
          if (sz == P) m_ovf = 1;
          else m_q.push_back(int'(free_id));
        end
      end
    end else begin
      if (!m_in_rat(m_scan)) m_q.push_back(m_scan);
      m_scan++;
      if (m_scan == P) m_rebuild = 0;
    end
  endfunction

  // Compare DUT outputs with the model mid-cycle, then advance the model.
  always @(negedge CLK) begin
    bit exp_valid;
    if (!RESET) begin
      m_reset();
      m_live = 1;
    end
    if (m_live) begin
      exp_valid = (m_q.size() > 0) && !m_rebuild && !FREEZE;
      chk("m_valid", 32'(alloc_valid), 32'(exp_valid));
      chk("m_count", 32'(count), 32'(m_q.size()));
      chk("m_busy",  32'(busy), 32'(m_rebuild));
      chk("m_ovf",   32'(ovf), 32'(m_ovf));
      if (exp_valid) chk("m_alloc_id", 32'(alloc_id), 32'(m_q[0]));
      if (RESET && !FREEZE) m_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    FREEZE = 0; alloc_req = 0; free_req = 0; copy = 0; free_id = '0;
  endtask

  task automatic pack_rat();
    for (int a = 0; a < A; a++) rat[(A-1-a)*TW +: TW] = TW'(rat_ids[a]);
  endtask

  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int b, n50, exp_id;
    idle_inputs();
    for (int a = 0; a < A; a++) rat_ids[a] = a + 10;
    pack_rat();

    // Reset state
    #1 RESET = 0;
    #1;
    chk("reset_count", 32'(count), 32);
    chk("reset_valid", 32'(alloc_valid), 1);
    chk("reset_id", 32'(alloc_id), 32);
    tick();
    RESET = 1;

    // Four allocations
    for (int k = 0; k < 4; k++) begin
      alloc_req = 1;
      #1 chk("alloc4_id", 32'(alloc_id), 32'(32 + k));
      tick();
    end
    alloc_req = 0;
    #1 chk("alloc4_count", 32'(count), 28);

    // Drain, then free with alloc when empty
    alloc_req = 1;
    repeat (28) tick();
    alloc_req = 0;
    #1 chk("empty_valid", 32'(alloc_valid), 0);
    chk("empty_count", 32'(count), 0);
    alloc_req = 1; free_req = 1; free_id = 6'd40;
    #1 chk("empty_nogrant", 32'(alloc_valid), 0);
    tick();
    idle_inputs();
    #1 chk("free40_count", 32'(count), 1);
    chk("free40_id", 32'(alloc_id), 40);

    // Fill to full, then overflow
    free_req = 1;
    for (int i = 0; i < 63; i++) begin
      free_id = TW'(i);
      tick();
    end
    #1 chk("full_count", 32'(count), 64);
    free_id = 6'd5;
    tick();
    free_req = 0;
    #1 chk("ovf_count", 32'(count), 64);
    chk("ovf_set", 32'(ovf), 1);
    alloc_req = 1;
    repeat (5) tick();
    alloc_req = 0;
    #1 chk("ovf_sticky", 32'(ovf), 1);
    chk("ovf_count59", 32'(count), 59);
    RESET = 0;
    #1 chk("ovf_reset", 32'(ovf), 0);
    tick();
    RESET = 1;

    // Rebuild with RetRAT r -> r+10
    copy = 1;
    tick();
    copy = 0;
    #1 chk("rb_busy", 32'(busy), 1);
    wait_not_busy(b);
    chk("rb_cycles", 32'(b), 64);
    #1 chk("rb_count", 32'(count), 32);
    for (int k = 0; k < 32; k++) begin
      exp_id = (k < 10) ? k : k + 32;
      alloc_req = 1;
      #1 chk("rb_alloc_id", 32'(alloc_id), 32'(exp_id));
      tick();
    end
    alloc_req = 0;

    // Frees of 50 in copy cycle and during rebuild are ignored
    copy = 1; free_req = 1; free_id = 6'd50;
    tick();
    copy = 0;
    repeat (10) tick();
    free_req = 0;
    wait_not_busy(b);
    chk("rb50_done", 32'(b < 200), 1);
    #1 chk("rb50_count", 32'(count), 32);
    n50 = 0;
    alloc_req = 1;
    for (int k = 0; k < 32; k++) begin
      #1 if (alloc_valid && alloc_id == 6'd50) n50++;
      tick();
    end
    alloc_req = 0;
    chk("rb50_once", 32'(n50), 1);

    // Reset 20 cycles into a rebuild
    copy = 1;
    tick();
    copy = 0;
    repeat (19) tick();
    RESET = 0;
    #1 chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_count", 32'(count), 32);
    tick();
    RESET = 1;
    #1 chk("rst_mid_id", 32'(alloc_id), 32);

    // Random traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int alloc_pct;
      alloc_pct = ((cyc / 400) % 2 == 0) ? 70 : 20;
      alloc_req = ($urandom_range(0, 99) < alloc_pct);
      free_req  = ($urandom_range(0, 99) < 45);
      free_id   = TW'($urandom_range(0, P - 1));
      FREEZE    = ($urandom_range(0, 99) < 8);
      copy      = ($urandom_range(0, 99) < 1);
      RESET     = !($urandom_range(0, 999) < 2);
      if ($urandom_range(0, 49) == 0) begin
        for (int a = 0; a < A; a++) rat_ids[a] = $urandom_range(0, P - 1);
        pack_rat();
      end
      tick();
    end
    idle_inputs();
    RESET = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 64: number of physical registers.
REQ-002 SHALL have parameter ARCH_REGS, default 32: number of architectural registers.
REQ-003 SHALL have parameter TAG_WIDTH, default 6: physical register ID width.
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port FREEZE  input  1  when high, holds all state; grants and pushes are suppressed.
REQ-007 SHALL have port tFL_allocReq_IN  input  1  rename requests one free physical register.
REQ-008 SHALL have port fFL_allocValid_OUT  output  1  a free ID is available and may be taken this cycle.
REQ-009 SHALL have port fFL_allocId_OUT  output  TAG_WIDTH  head free ID; valid when fFL_allocValid_OUT is high.
REQ-010 SHALL have port tFL_freeReq_IN  input  1  commit returns a physical register.
REQ-011 SHALL have port tFL_freeId_IN  input  TAG_WIDTH  physical ID being returned.
REQ-012 SHALL have port tFL_copyRetRat_IN  input  1  mispredict/exception recovery pulse from commit.
REQ-013 SHALL have port tFL_retRat_IN  input  TAG_WIDTH*ARCH_REGS  packed retirement RAT; arch reg 0 in the MSB field, arch reg 31 in the LSB field.
REQ-014 SHALL have port fFL_busy_OUT  output  1  a rebuild is in progress.
REQ-015 SHALL have port fFL_count_OUT  output  TAG_WIDTH+1  number of free IDs held.
REQ-016 SHALL have port fFL_overflow_OUT  output  1  sticky error: a free was attempted while full.

Function
REQ-017 SHALL store free IDs in a circular FIFO of PHYS_REGS entries with head/tail pointers of TAG_WIDTH bits that wrap modulo PHYS_REGS.
REQ-018 SHALL drive fFL_allocValid_OUT = (count != 0) && state==IDLE && !FREEZE, combinationally.
REQ-019 SHALL drive fFL_allocId_OUT from the FIFO head combinationally (zero latency); the pop takes effect on the edge where tFL_allocReq_IN && fFL_allocValid_OUT.
REQ-020 SHALL, in IDLE with tFL_freeReq_IN high and count < PHYS_REGS, write tFL_freeId_IN at the tail and advance the tail.
REQ-021 SHALL, on a free while count == PHYS_REGS, drop the ID and set fFL_overflow_OUT until reset.
REQ-022 SHALL handle a simultaneous alloc and free in one cycle as pop plus push, count unchanged; when count == 0, the alloc is not granted and the free is pushed.
REQ-023 SHALL implement states IDLE and REBUILD; IDLE -> REBUILD on tFL_copyRetRat_IN && !FREEZE; REBUILD -> IDLE after the last scan step.
REQ-024 SHALL, on entering REBUILD, capture tFL_retRat_IN into a PHYS_REGS-bit in-use bitmap, clear head, tail and count, and zero a scan index.
REQ-025 SHALL, in REBUILD, examine one physical ID per cycle, index 0 through PHYS_REGS-1, pushing the index when its in-use bit is clear; REBUILD lasts exactly PHYS_REGS cycles.
REQ-026 SHALL ignore tFL_freeReq_IN in the copy cycle and throughout REBUILD, because a freed ID that is absent from the RetRAT is recovered by the scan.
REQ-027 SHALL ignore a tFL_copyRetRat_IN that arrives during REBUILD.
REQ-028 SHALL assert fFL_busy_OUT whenever state == REBUILD.
REQ-029 SHALL tolerate duplicate IDs in the RetRAT; the resulting count is PHYS_REGS minus the number of distinct RetRAT IDs.

Reset
REQ-030 SHALL, on RESET low, asynchronously load FIFO entries 0..31 with IDs 32..63 and set head=0, tail=32, count=32, state=IDLE, fFL_busy_OUT=0, fFL_overflow_OUT=0.
REQ-031 SHALL abort a REBUILD in progress when reset is asserted mid-operation, returning to the REQ-030 state.

Structure
REQ-032 SHALL take PHYS_REGS, ARCH_REGS, TAG_WIDTH and the IDLE/REBUILD state encoding from a shared rename package.
REQ-033 SHALL place the storage in one sub-module, fl_tag_fifo, which provides push, pop, clear, count and reset preload; the state machine and scan stay in free_list.

Verification
REQ-034 SHALL cover: reset -> count=32, allocValid=1, allocId=32; four allocations -> IDs 32,33,34,35 and count=28.
REQ-035 SHALL cover: allocate all 32 IDs -> allocValid=0; free ID 40 with allocReq high in the same cycle -> no grant, count=1, next allocId=40.
REQ-036 SHALL cover: at count=64, free ID 5 -> ID dropped, overflow=1 and it stays 1 until reset.
REQ-037 SHALL cover: copyRetRat with RetRAT mapping arch r -> phys r+10 (IDs 10..41) -> busy for exactly 64 cycles, then count=32 and allocations give 0..9 then 42..63.
REQ-038 SHALL cover: free ID 50 in the copy cycle and again during REBUILD -> both ignored; ID 50 appears once after rebuild only if it is absent from the RetRAT.
REQ-039 SHALL cover: RESET asserted 20 cycles into REBUILD -> busy=0 and count=32 immediately, then allocId=32.
